// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the multi-set trapezoidal fuzzifier.
// The build-time parameters live here so that every file sees the same widths.
package fuzzy_pkg;

  localparam int IN_W      = 4;
  localparam int LONGBIT_W = 10;
  localparam int NUM_SETS  = 4;
  localparam int SET_IDX_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int LEVEL_W   = $clog2(LONGBIT_W + 1);
  localparam int ARITH_W   = IN_W + LEVEL_W + 1;

  localparam int FLAG_UP   = 2;
  localparam int FLAG_CORE = 1;
  localparam int FLAG_DOWN = 0;

  typedef logic [IN_W-1:0]      in_t;
  typedef logic [LONGBIT_W-1:0] longbit_t;
  typedef logic [2:0]           flag_t;
  typedef logic [SET_IDX_W-1:0] set_idx_t;
  typedef logic [LEVEL_W-1:0]   level_t;
  typedef logic [ARITH_W-1:0]   arith_t;

  typedef struct packed {
    in_t n0;
    in_t n1;
    in_t n2;
    in_t n3;
  } node_set_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam node_set_t NODE_RST = '{n0: in_t'(0), n1: in_t'(1), n2: in_t'(2), n3: in_t'(3)};
  localparam set_idx_t  LAST_IDX = set_idx_t'(NUM_SETS - 1);

  function automatic level_t popCount(input longbit_t v);
    level_t c;
    c = '0;
    for (int i = 0; i < LONGBIT_W; i++) c = c + level_t'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/fuzzy_trap_eval.sv
// Combinational evaluation of one crisp sample against one trapezoid.
// Produces region flags and a thermometer-coded membership word.
module fuzzy_trap_eval
  import fuzzy_pkg::*;
(
  input  in_t       X,
  input  node_set_t Nodes,
  output logic      IsHit,
  output flag_t     LocalFlag,
  output longbit_t  LongBitData,
  output logic      ErrorReturn
);

  arith_t   xA, n0A, n1A, n2A, n3A;
  longbit_t riseCode, fallCode;

  assign xA  = arith_t'(X);
  assign n0A = arith_t'(Nodes.n0);
  assign n1A = arith_t'(Nodes.n1);
  assign n2A = arith_t'(Nodes.n2);
  assign n3A = arith_t'(Nodes.n3);

  // Cross-multiplied ramp compare; a degenerate edge has zero span, so every bit is set.
  always_comb begin
    riseCode = '0;
    fallCode = '0;
    for (int j = 0; j < LONGBIT_W; j++) begin
      riseCode[j] = ((xA - n0A) * arith_t'(LONGBIT_W)) >= (arith_t'(j + 1) * (n1A - n0A));
      fallCode[j] = ((n3A - xA) * arith_t'(LONGBIT_W)) >= (arith_t'(j + 1) * (n3A - n2A));
    end
  end

  // NOTE: every output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    IsHit       = 1'b0;
    LocalFlag   = '0;
    LongBitData = '0;
    ErrorReturn = (Nodes.n0 > Nodes.n1) || (Nodes.n1 > Nodes.n2) || (Nodes.n2 > Nodes.n3);
    if (!ErrorReturn) begin
      if (X < Nodes.n0 || X > Nodes.n3) begin
        IsHit = 1'b1;
      end else begin
        LocalFlag[FLAG_UP]   = (X <= Nodes.n1);
        LocalFlag[FLAG_CORE] = (X >= Nodes.n1) && (X <= Nodes.n2);
        LocalFlag[FLAG_DOWN] = (X >= Nodes.n2);
        if (LocalFlag[FLAG_DOWN])      LongBitData = fallCode;
        else if (LocalFlag[FLAG_CORE]) LongBitData = '1;
        else                           LongBitData = riseCode;
      end
    end
  end

endmodule

// File: rtl/fuzzy_trap_mapper.sv
// Multi-set fuzzifier: latches one sample, then streams one membership result per set.
// Optional max-membership tracker enabled by defining FUZZY_MAX_TRACK_EN.
module fuzzy_trap_mapper
  import fuzzy_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       InValid,
  output logic       InReady,
  input  in_t        InFixed,
  input  logic       CfgWe,
  input  set_idx_t   CfgSet,
  input  logic [1:0] CfgNode,
  input  in_t        CfgData,
  output logic       CfgErr,
  output logic       OutValid,
  input  logic       OutReady,
  output set_idx_t   OutSetIdx,
  output logic       OutLast,
  output logic       IsHit,
  output flag_t      LocalFlag,
  output longbit_t   LongBitData,
  output logic       ErrorReturn
`ifdef FUZZY_MAX_TRACK_EN
  ,
  output set_idx_t   MaxSetIdx,
  output level_t     MaxLevel
`endif
);

  state_t    state, nextState;
  set_idx_t  idx;
  in_t       xReg;
  node_set_t nodes [NUM_SETS];

  logic      evalHit, evalErr;
  flag_t     evalFlag;
  longbit_t  evalData;

  always_comb begin
    nextState = state;
    InReady   = 1'b0;
    OutValid  = (state == HOLD);
    unique case (state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) nextState = EVAL;
      end
      EVAL: nextState = HOLD;
      HOLD: if (OutReady) nextState = (idx == LAST_IDX) ? IDLE : EVAL;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= nextState;
  end

  fuzzy_trap_eval uEval (
    .X          (xReg),
    .Nodes      (nodes[idx]),
    .IsHit      (evalHit),
    .LocalFlag  (evalFlag),
    .LongBitData(evalData),
    .ErrorReturn(evalErr)
  );

  // NOTE: the node file is a handful of flops with defined reset contents, so it is reset like logic.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx         <= '0;
      xReg        <= '0;
      CfgErr      <= 1'b0;
      OutSetIdx   <= '0;
      OutLast     <= 1'b0;
      IsHit       <= 1'b0;
      LocalFlag   <= '0;
      LongBitData <= '0;
      ErrorReturn <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) nodes[s] <= NODE_RST;
    end else begin
      CfgErr <= CfgWe && (state != IDLE);
      // A write on the handshake edge lands before EVAL reads the node file.
      if (state == IDLE && CfgWe && int'(CfgSet) < NUM_SETS) begin
        unique case (CfgNode)
          2'd0: nodes[CfgSet].n0 <= CfgData;
          2'd1: nodes[CfgSet].n1 <= CfgData;
          2'd2: nodes[CfgSet].n2 <= CfgData;
          2'd3: nodes[CfgSet].n3 <= CfgData;
          default: ;
        endcase
      end
      if (state == IDLE && InValid) begin
        xReg <= InFixed;
        idx  <= '0;
      end
      if (state == EVAL) begin
        OutSetIdx   <= idx;
        OutLast     <= (idx == LAST_IDX);
        IsHit       <= evalHit;
        LocalFlag   <= evalFlag;
        LongBitData <= evalData;
        ErrorReturn <= evalErr;
      end
      if (state == HOLD && OutReady && idx != LAST_IDX) idx <= idx + set_idx_t'(1);
    end
  end

`ifdef FUZZY_MAX_TRACK_EN
  set_idx_t maxIdx;
  level_t   maxLvl, curLvl;

  assign curLvl = popCount(evalData);

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge Clk) begin
    if (Rst || (state == IDLE && InValid)) begin
      maxIdx <= '0;
      maxLvl <= '0;
    end else if (state == EVAL && curLvl > maxLvl) begin
      maxIdx <= idx;
      maxLvl <= curLvl;
    end
  end

  assign MaxSetIdx = maxIdx;
  assign MaxLevel  = maxLvl;
`endif

endmodule
